// File: rtl/vga_overlay_compositor.sv
// vga_overlay_compositor: N_OBJ rectangle overlay plus grid on XVGA timing, 4-cycle pipeline; define VGA_OVERLAY_ALPHA_EN to blend the top two overlapping objects
module vga_overlay_compositor #(
  parameter int          N_OBJ        = 4,
  parameter int          OBJ_W        = 16,
  parameter int          OBJ_H        = 16,
  parameter int          H_ACTIVE     = 1024,
  parameter int          V_ACTIVE     = 768,
  parameter int          GRID_LOG2    = 6,
  parameter logic [23:0] GRID_COLOR   = 24'hFFFFFF,
  parameter logic [23:0] BLANK_COLOR  = 24'h000000,
  parameter int          ALPHA_M      = 2,
  parameter int          ALPHA_N_LOG2 = 2
) (
  input  logic        vclock,
  input  logic        reset,
  input  logic [10:0] hcount,
  input  logic [9:0]  vcount,
  input  logic        hsync,
  input  logic        vsync,
  input  logic        blank,
  input  logic        upd_valid,
  output logic        upd_ready,
  input  logic [2:0]  upd_idx,
  input  logic [11:0] upd_x,
  input  logic [11:0] upd_y,
  input  logic [23:0] upd_color,
  input  logic        upd_visible,
  output logic        commit_pulse,
  output logic        phsync,
  output logic        pvsync,
  output logic        pblank,
  output logic [23:0] pixel
);
  typedef struct packed {
    logic        visible;
    logic [11:0] x;
    logic [11:0] y;
    logic [23:0] color;
  } slot_t;
  localparam logic signed [12:0] HALF_W = 13'(OBJ_W / 2);
  localparam logic signed [12:0] HALF_H = 13'(OBJ_H / 2);
  if (N_OBJ < 1 || N_OBJ > 8 || OBJ_W % 2 != 0 || OBJ_H % 2 != 0 || ALPHA_M > (1 << ALPHA_N_LOG2)) begin : g_bad_cfg
    $error("vga_overlay_compositor: unsupported parameter set");
  end
  slot_t              shadow [N_OBJ];
  slot_t              active [N_OBJ];
  logic               vsync_q;
  logic               fall;
  logic signed [11:0] x_value;
  logic signed [11:0] y_value;
  logic [N_OBJ-1:0]   hit;
  logic               grid_hit;
  logic [23:0]        c1;
  logic [1:0]         n_hits;
  logic [3:0]         hs_d;
  logic [3:0]         vs_d;
  logic [3:0]         bl_d;
  logic [23:0]        s1_c1;
  logic [1:0]         s1_n;
  logic               s1_grid;
  logic [23:0]        s2_obj;
  logic               s2_any;
  logic               s2_grid;
  logic [23:0]        s3_color;
`ifdef VGA_OVERLAY_ALPHA_EN
  logic [23:0]        c2;
  logic [23:0]        s1_c2;
  logic [23:0]        mix;
`endif
  assign fall      = vsync_q & ~vsync;
  assign upd_ready = ~commit_pulse;
  assign phsync    = hs_d[3];
  assign pvsync    = vs_d[3];
  assign pblank    = bl_d[3];
  assign x_value   = {1'b0, hcount} - 12'(H_ACTIVE / 2);
  assign y_value   = 12'(V_ACTIVE) - {2'b0, vcount};
  assign grid_hit  = x_value[GRID_LOG2-1:0] == '0 || y_value[GRID_LOG2-1:0] == '0;
  for (genvar i = 0; i < N_OBJ; i++) begin : g_hit
    logic signed [12:0] dx;
    logic signed [12:0] dy;
    assign dx     = {x_value[11], x_value} - {active[i].x[11], active[i].x};
    assign dy     = {y_value[11], y_value} - {active[i].y[11], active[i].y};
    assign hit[i] = active[i].visible && dx > -HALF_W && dx < HALF_W && dy > -HALF_H && dy < HALF_H;
  end
  always_comb begin
    c1     = '0;
`ifdef VGA_OVERLAY_ALPHA_EN
    c2     = '0;
`endif
    n_hits = '0;
    for (int i = N_OBJ - 1; i >= 0; i--)
      if (hit[i]) begin
`ifdef VGA_OVERLAY_ALPHA_EN
        c2     = c1;
`endif
        c1     = active[i].color;
        n_hits = n_hits == 2'd2 ? 2'd2 : n_hits + 2'd1;
      end
  end
`ifdef VGA_OVERLAY_ALPHA_EN
  for (genvar k = 0; k < 3; k++) begin : g_mix
    logic [9:0] sum;
    assign sum           = s1_c1[8*k +: 8] * 10'(ALPHA_M) + s1_c2[8*k +: 8] * 10'((1 << ALPHA_N_LOG2) - ALPHA_M);
    assign mix[8*k +: 8] = 8'(sum >> ALPHA_N_LOG2);
  end
`endif
  always_ff @(posedge vclock or posedge reset)
    if (reset) begin
      vsync_q      <= 1'b1;
      commit_pulse <= 1'b0;
      hs_d         <= '1;
      vs_d         <= '1;
      bl_d         <= '1;
      s1_c1        <= '0;
`ifdef VGA_OVERLAY_ALPHA_EN
      s1_c2        <= '0;
`endif
      s1_n         <= '0;
      s1_grid      <= 1'b0;
      s2_obj       <= '0;
      s2_any       <= 1'b0;
      s2_grid      <= 1'b0;
      s3_color     <= '0;
      pixel        <= BLANK_COLOR;
      for (int i = 0; i < N_OBJ; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
    end else begin
      vsync_q      <= vsync;
      commit_pulse <= fall;
      hs_d         <= {hs_d[2:0], hsync};
      vs_d         <= {vs_d[2:0], vsync};
      bl_d         <= {bl_d[2:0], blank};
      s1_c1        <= c1;
`ifdef VGA_OVERLAY_ALPHA_EN
      s1_c2        <= c2;
      s2_obj       <= s1_n == 2'd2 ? mix : s1_c1;
`else
      s2_obj       <= s1_c1;
`endif
      s1_n         <= n_hits;
      s1_grid      <= grid_hit;
      s2_any       <= s1_n != 2'd0;
      s2_grid      <= s1_grid;
      s3_color     <= s2_any ? s2_obj : s2_grid ? GRID_COLOR : BLANK_COLOR;
      pixel        <= bl_d[2] ? BLANK_COLOR : s3_color;
      for (int i = 0; i < N_OBJ; i++) begin
        if (commit_pulse)
          active[i] <= shadow[i];
        if (upd_valid && upd_ready && upd_idx == 3'(i))
          shadow[i] <= {upd_visible, upd_x, upd_y, upd_color};
      end
    end
endmodule

// File: tb/tb_vga_overlay_compositor.sv
// tb_vga_overlay_compositor: randomized and directed stimulus against a frame-level reference model
module tb_vga_overlay_compositor;
  localparam int N_OBJ = 4;
  localparam int OBJ_W = 16;
  localparam int OBJ_H = 16;
  localparam int H_ACTIVE = 1024;
  localparam int V_ACTIVE = 768;
  localparam int GRID = 64;
  localparam int AM = 2;
  localparam int AN = 4;

  logic        vclock = 1'b0;
  logic        reset;
  logic [10:0] hcount;
  logic [9:0]  vcount;
  logic        hsync, vsync, blank;
  logic        upd_valid, upd_ready;
  logic [2:0]  upd_idx;
  logic [11:0] upd_x, upd_y;
  logic [23:0] upd_color;
  logic        upd_visible;
  logic        commit_pulse, phsync, pvsync, pblank;
  logic [23:0] pixel;

  vga_overlay_compositor dut (
    .vclock(vclock), .reset(reset), .hcount(hcount), .vcount(vcount),
    .hsync(hsync), .vsync(vsync), .blank(blank),
    .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_idx(upd_idx),
    .upd_x(upd_x), .upd_y(upd_y), .upd_color(upd_color), .upd_visible(upd_visible),
    .commit_pulse(commit_pulse), .phsync(phsync), .pvsync(pvsync), .pblank(pblank),
    .pixel(pixel)
  );

  always #5 vclock = ~vclock;

  typedef struct {bit vis; int x; int y; bit [23:0] c;} obj_t;
  typedef struct {bit [23:0] pix; bit hs; bit vs; bit bl;} exp_t;
  obj_t sh [N_OBJ];
  obj_t ac [N_OBJ];
  bit   m_cp, m_vsq;
  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(string tag, logic [23:0] got, logic [23:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h, expected %h", tag, $time, got, exp);
    end
  endtask

  function automatic int iabs(int v);
    return v < 0 ? -v : v;
  endfunction

  function automatic bit [23:0] ref_pixel(int x, int y);
    bit [23:0] hits[$];
    bit [23:0] r;
    foreach (ac[i])
      if (ac[i].vis && iabs(x - ac[i].x) < OBJ_W / 2 && iabs(y - ac[i].y) < OBJ_H / 2)
        hits.push_back(ac[i].c);
    if (hits.size() == 0)
      return (x % GRID == 0 || y % GRID == 0) ? 24'hFFFFFF : 24'h000000;
`ifdef VGA_OVERLAY_ALPHA_EN
    if (hits.size() > 1) begin
      for (int k = 0; k < 3; k++)
        r[8*k +: 8] = 8'((int'(hits[0][8*k +: 8]) * AM + int'(hits[1][8*k +: 8]) * (AN - AM)) / AN);
      return r;
    end
`endif
    r = hits[0];
    return r;
  endfunction

  task automatic model_reset();
    foreach (sh[i]) begin
      sh[i] = '{default: 0};
      ac[i] = '{default: 0};
    end
    m_cp  = 1'b0;
    m_vsq = 1'b1;
    q.delete();
    repeat (3) q.push_back('{24'h0, 1'b1, 1'b1, 1'b1});
  endtask

  task automatic step();
    exp_t e;
    e.pix = blank ? 24'h0 : ref_pixel(int'(hcount) - H_ACTIVE / 2, V_ACTIVE - int'(vcount));
    e.hs  = hsync;
    e.vs  = vsync;
    e.bl  = blank;
    q.push_back(e);
    @(posedge vclock);
    if (m_cp)
      ac = sh;
    else if (upd_valid && upd_idx < N_OBJ)
      sh[upd_idx] = '{upd_visible, int'($signed(upd_x)), int'($signed(upd_y)), upd_color};
    m_cp  = m_vsq && !vsync;
    m_vsq = vsync;
    #1;
    e = q.pop_front();
    check("pixel", pixel, e.pix);
    check("phsync", phsync, e.hs);
    check("pvsync", pvsync, e.vs);
    check("pblank", pblank, e.bl);
    check("commit_pulse", commit_pulse, m_cp);
    check("upd_ready", upd_ready, !m_cp);
  endtask

  task automatic put(int x, int y);
    hcount = 11'(x + H_ACTIVE / 2);
    vcount = 10'(V_ACTIVE - y);
  endtask

  task automatic rand_pix(bit near);
    int s;
    s = $urandom_range(0, N_OBJ - 1);
    if (near && ac[s].vis)
      put(ac[s].x + int'($urandom_range(0, 20)) - 10, ac[s].y + int'($urandom_range(0, 20)) - 10);
    else begin
      hcount = 11'($urandom_range(0, 1023));
      vcount = 10'($urandom_range(0, 767));
    end
    hsync = 1'($urandom);
    blank = $urandom_range(0, 9) == 0;
  endtask

  task automatic probe(int x, int y);
    blank = 1'b0;
    repeat (6) begin
      put(x, y);
      step();
    end
  endtask

  task automatic write(int idx, int x, int y, bit [23:0] c, bit vis);
    upd_valid   = 1'b1;
    upd_idx     = 3'(idx);
    upd_x       = 12'(x);
    upd_y       = 12'(y);
    upd_color   = c;
    upd_visible = vis;
    step();
    upd_valid   = 1'b0;
  endtask

  task automatic frame();
    vsync = 1'b0;
    repeat (2) step();
    vsync = 1'b1;
    step();
  endtask

  initial begin
    reset = 1'b1;
    hcount = '0; vcount = '0; hsync = 1'b1; vsync = 1'b1; blank = 1'b0;
    upd_valid = 1'b0; upd_idx = '0; upd_x = '0; upd_y = '0; upd_color = '0; upd_visible = 1'b0;
    model_reset();
    repeat (3) @(posedge vclock);
    #1;
    check("rst_pixel", pixel, 24'h0);
    check("rst_phsync", phsync, 1'b1);
    check("rst_pvsync", pvsync, 1'b1);
    check("rst_pblank", pblank, 1'b1);
    check("rst_ready", upd_ready, 1'b1);
    check("rst_commit", commit_pulse, 1'b0);
    reset = 1'b0;
    for (int c = 0; c < 300; c++) begin
      rand_pix(1'b0);
      step();
    end
    probe(0, 200);
    probe(-64, 64);
    probe(-63, 65);
    write(0, 0, 100, 24'hFF0000, 1'b1);
    probe(0, 100);
    frame();
    probe(0, 100);
    probe(7, 107);
    probe(8, 100);
    write(1, 0, 100, 24'h0000FF, 1'b1);
    frame();
    probe(0, 100);
    vsync = 1'b0;
    step();
    upd_valid = 1'b1; upd_idx = 3'd3; upd_x = 12'd200; upd_y = 12'd100; upd_color = 24'h00FF00; upd_visible = 1'b1;
    repeat (3) step();
    upd_valid = 1'b0;
    vsync = 1'b1;
    probe(200, 100);
    frame();
    probe(200, 100);
    write(7, 0, 100, 24'h123456, 1'b1);
    write(2, -100, 300, 24'hAA5500, 1'b1);
    write(2, -100, 300, 24'h0055AA, 1'b1);
    probe(-100, 300);
    frame();
    probe(-100, 300);
    probe(0, 100);
    for (int c = 0; c < 4000; c++) begin
      vsync       = (c % 200) < 192;
      upd_valid   = $urandom_range(0, 3) == 0;
      upd_idx     = 3'($urandom_range(0, 7));
      upd_x       = 12'(int'($urandom_range(0, 80)) - 40);
      upd_y       = 12'($urandom_range(60, 140));
      upd_color   = 24'($urandom);
      upd_visible = $urandom_range(0, 3) != 0;
      rand_pix($urandom_range(0, 9) < 7);
      step();
    end
    upd_valid = 1'b0;
    vsync = 1'b1;
    write(0, 0, 100, 24'hFF0000, 1'b1);
    frame();
    probe(0, 100);
    #2 reset = 1'b1;
    #1;
    check("midrst_pixel", pixel, 24'h0);
    check("midrst_pblank", pblank, 1'b1);
    check("midrst_ready", upd_ready, 1'b1);
    check("midrst_commit", commit_pulse, 1'b0);
    repeat (2) @(posedge vclock);
    #1 reset = 1'b0;
    model_reset();
    probe(0, 100);
    frame();
    probe(0, 100);
    for (int c = 0; c < 300; c++) begin
      rand_pix(1'b0);
      step();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/vga_overlay_compositor.md
Name: vga_overlay_compositor

Overview:
- Parametrised successor to the single-rover/single-target VGA writer.
- Composites up to N_OBJ rectangular markers (rover, targets, waypoints) over a power-of-two grid.
- Per-object position, colour and visibility are loaded through a valid/ready port into shadow registers. All objects commit atomically at each frame boundary.
- Sits between the XVGA timing generator and the VGA DAC output register.

Parameters:
- N_OBJ, 4: number of object slots (1..8).
- OBJ_W, 16: object width in pixels (even).
- OBJ_H, 16: object height in pixels (even).
- H_ACTIVE, 1024: active width; x origin is at H_ACTIVE/2.
- V_ACTIVE, 768: active height; y origin is at the bottom edge.
- GRID_LOG2, 6: grid pitch is 2**GRID_LOG2 pixels.
- GRID_COLOR, 24'hFFFFFF: grid line colour.
- BLANK_COLOR, 24'h000000: background colour.
- ALPHA_M, 2: blend numerator.
- ALPHA_N_LOG2, 2: blend denominator is 2**ALPHA_N_LOG2.

Ports:
- vclock  in  1  65 MHz pixel clock.
- reset  in  1  asynchronous, active-high.
- hcount  in  11  horizontal pixel index.
- vcount  in  10  vertical pixel index.
- hsync  in  1  active-low horizontal sync.
- vsync  in  1  active-low vertical sync.
- blank  in  1  1 = blanking interval.
- upd_valid  in  1  object update offered.
- upd_ready  out  1  update accepted when valid&ready.
- upd_idx  in  3  target slot.
- upd_x  in  12  signed centre x.
- upd_y  in  12  signed centre y.
- upd_color  in  24  object colour.
- upd_visible  in  1  slot enable.
- commit_pulse  out  1  one-cycle pulse when shadow copied to active.
- phsync  out  1  hsync delayed by LATENCY.
- pvsync  out  1  vsync delayed by LATENCY.
- pblank  out  1  blank delayed by LATENCY.
- pixel  out  24  r=23:16, g=15:8, b=7:0.

Behaviour:
- Reset (async):
  - pixel=BLANK_COLOR, phsync=1, pvsync=1, pblank=1.
  - upd_ready=1, commit_pulse=0.
  - All shadow and active slots: visible=0, x=0, y=0, colour=0.
  - All pipeline registers cleared.
- Coordinates:
  - x_value = hcount − H_ACTIVE/2, 12-bit signed.
  - y_value = V_ACTIVE − vcount, 12-bit signed.
  - All compares are signed.
- Update port:
  - A transfer occurs on a clock where upd_valid&upd_ready; it writes shadow[upd_idx].
  - Repeated writes to one slot before a commit: last write wins.
  - upd_idx ≥ N_OBJ: the handshake completes and the data is discarded.
- Commit:
  - Register vsync to form vsync_q. A falling edge is vsync_q=1 & vsync=0.
  - On the falling edge, copy all shadow slots to active slots in one cycle and pulse commit_pulse for that cycle.
  - upd_ready=0 during the commit cycle only. Updates offered then are held off; they are not lost.
  - Active slots never change between commits, so there is no mid-frame tearing.
- Pipeline, LATENCY=4, runs every cycle regardless of sync:
  - S1: register x_value/y_value. Compute per-slot hit = visible & |x−cx| < OBJ_W/2 & |y−cy| < OBJ_H/2. Compute grid_hit = (x[GRID_LOG2-1:0]==0 | y[GRID_LOG2-1:0]==0).
  - S2: priority-encode hits, lowest index highest priority. Produce c1 (first hit colour), c2 (second hit colour), n_hits saturated at 2, and the grid flag.
  - S3: n_hits=2 → per channel (c1*ALPHA_M + c2*(2**ALPHA_N_LOG2−ALPHA_M)) >> ALPHA_N_LOG2, computed in 10 bits and truncated to 8. n_hits=1 → c1. n_hits=0 → GRID_COLOR if grid flag, else BLANK_COLOR.
  - S4: pixel register. Force BLANK_COLOR when the delayed blank is 1.
- Sync delay: hsync, vsync and blank are delayed by exactly LATENCY clocks through shift registers. These reset to 1.
- Objects partly off-screen clip naturally. Coordinates outside ±2047 are not supported.
- Reset asserted mid-frame: all objects disappear immediately. Output returns to grid/blank within LATENCY cycles after release.

Optional Feature:
- Macro: VGA_OVERLAY_ALPHA_EN.
- Defined: S3 blends the top two overlapping objects as described above.
- Undefined: c2 logic is removed and the top-priority hit is drawn opaque. Latency stays 4 so downstream timing is unchanged.

Test Plan:
- Reset, no updates, drive full frame → pixel=24'hFFFFFF at x_value=0 / y_value=64 lines, 0 elsewhere; phsync/pvsync/pblank equal inputs delayed 4 cycles.
- Write slot0 x=0 y=100 colour FF0000 visible, then vsync fall → commit_pulse once; pixel at (hcount=512, vcount=668) = FF0000 four cycles later; before the commit the same pixel is grid/blank.
- Slot0 FF0000 and slot1 0000FF overlap at the same centre → blended pixel 7F007F with ALPHA_EN; FF0000 without it.
- Hold upd_valid across a vsync fall → upd_ready low exactly one cycle; the write lands the next cycle and is visible only after the following commit.
- Write upd_idx=7 with N_OBJ=4 → handshake completes and the frame is unchanged; two writes to slot2 before a commit → only the second colour is displayed.
- Assert reset mid-line with objects visible → pixel=0 and pblank=1 immediately; after release, the objects stay invisible until new updates are committed.
